// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector.
//   state_t     : detector FSM encoding (IDLE=0, FILL=1, HUNT=2)
//   DEF_*_C     : configuration loaded at reset
//   len_ok()    : pattern-length legality (1..max_len)
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    localparam int unsigned DEF_MAX_LEN_C = 8;
    localparam int unsigned DEF_CNT_W_C   = 8;
    localparam logic [31:0] DEF_PATTERN_C = 32'h0000_000B;
    localparam int unsigned DEF_LEN_C     = 4;
    localparam logic        DEF_OVERLAP_C = 1'b0;

    function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter.
//   clk, rst : clock, synchronous active-low reset
//   clr      : clear (wins over inc; a same-cycle inc leaves the count at 1)
//   inc      : count one match
//   cnt      : current count
//   sat      : high while cnt is all-ones
module seq_match_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    assign sat = &cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial sequence detector.
//   clk, rst    : clock, synchronous active-low reset
//   en          : detector enable (low returns to IDLE, clears history)
//   in_valid    : qualifies in_bit
//   in_bit      : serial data
//   cfg_load    : strobe loading cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern : pattern, bit [cfg_len-1] received first, bit [0] last
//   cfg_len     : pattern length 1..MAX_LEN
//   cfg_overlap : 1 = overlapping detection
//   cnt_clr     : clears match_cnt
//   match       : registered one-cycle pulse per detection
//   match_cnt   : saturating match count
//   cnt_sat     : match_cnt is all-ones
//   cfg_err     : one-cycle pulse after a rejected cfg_load
//   state_o     : FSM state for debug
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned          MAX_LEN     = DEF_MAX_LEN_C,
    parameter int unsigned          CNT_W       = DEF_CNT_W_C,
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = DEF_PATTERN_C[MAX_LEN-1:0],
    parameter int unsigned          DEF_LEN     = DEF_LEN_C,
    parameter logic                 DEF_OVERLAP = DEF_OVERLAP_C
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic                         in_bit,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cnt_clr,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cnt_sat,
    output logic                         cfg_err,
    output logic [1:0]                   state_o
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    state_t             state;
    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      len;
    logic               overlap;
    logic [MAX_LEN-1:0] hist;
    logic [LW-1:0]      fill;

    logic               cfg_ok;
    logic               accept;
    logic               enough;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN:0]   win;
    logic               hit;
    logic [LW-1:0]      fill_next;

    assign cfg_ok = len_ok(32'(cfg_len), MAX_LEN);
    assign accept = en && in_valid && !cfg_load;
    assign win    = {hist, in_bit};
    // fill >= len-1, written as fill+1 >= len to stay unsigned-safe
    assign enough = ({1'b0, fill} + {{LW{1'b0}}, 1'b1}) >= {1'b0, len};

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len));
        end
    end

    assign hit = accept && enough && ((win[MAX_LEN-1:0] & mask) == (pat & mask));

    // Non-overlap restarts the fill after a hit; overlap keeps it saturated.
    always_comb begin
        fill_next = fill;
        if (accept) begin
            if (hit && !overlap) begin
                fill_next = '0;
            end else if (fill != len) begin
                fill_next = fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat     <= DEF_PATTERN;
            len     <= LW'(DEF_LEN);
            overlap <= DEF_OVERLAP;
            hist    <= '0;
            fill    <= '0;
            state   <= IDLE;
            match   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            match   <= hit;
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_load && cfg_ok) begin
                pat     <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
                hist    <= '0;
                fill    <= '0;
                state   <= en ? FILL : IDLE;
            end else if (!en) begin
                hist  <= '0;
                fill  <= '0;
                state <= IDLE;
            end else begin
                if (accept) begin
                    hist <= {hist[MAX_LEN-2:0], in_bit};
                end
                fill <= fill_next;
                // HUNT exactly while the window is full
                if (state == IDLE) begin
                    state <= FILL;
                end else begin
                    state <= (fill_next >= len) ? HUNT : FILL;
                end
            end
        end
    end

    assign state_o = state;

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (hit),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule
